// File: rtl/core_bus_arbiter_pkg.sv
// Shared definitions for the core-side bus arbiter: FSM state codes, cbus
// request/response records and size codes.
package core_bus_arbiter_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_IBUSY = 3'd1;
    localparam logic [2:0] ST_DBUSY = 3'd2;
    localparam logic [2:0] ST_IRESP = 3'd3;
    localparam logic [2:0] ST_DRESP = 3'd4;

    typedef enum logic [2:0] {
        SIZE_1B = 3'd0,
        SIZE_2B = 3'd1,
        SIZE_4B = 3'd2,
        SIZE_8B = 3'd3
    } size_e;

    typedef struct packed {
        logic        valid;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    // A fetch returns the 32-bit half of the 64-bit beat selected by addr[2].
    function automatic logic [31:0] fetch_word(input logic [63:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/core_bus_arbiter.sv
// Merges the core's fetch (ibus) and load/store (dbus) requests onto one
// single-beat memory bus; data side wins unless fetch has been starved.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no transaction; arbitrate between ireq and dreq
//   ST_IBUSY | fetch latched on cbus, waiting for the last beat
//   ST_DBUSY | data access latched on cbus, waiting for the last beat
//   ST_IRESP | one-cycle addr_ok/data_ok to the fetch side
//   ST_DRESP | one-cycle addr_ok/data_ok to the data side
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
#(
    parameter int         STARVE_LIMIT = 4,
    parameter logic [2:0] FETCH_SIZE   = 3'b010
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,

    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,

    output logic        creq_valid,
    output logic        creq_is_write,
    output logic [2:0]  creq_size,
    output logic [63:0] creq_addr,
    output logic [7:0]  creq_strobe,
    output logic [63:0] creq_data,
    input  logic        cresp_ready,
    input  logic        cresp_last,
    input  logic [63:0] cresp_data
);

    localparam int              CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [2:0]       state;
    cbus_req_t        req_q;
    cbus_resp_t       resp;
    logic [CNT_W-1:0] starve_cnt;
    logic [31:0]      iresp_data_q;
    logic [63:0]      dresp_data_q;
    logic             starve_hit;
    logic             grant_d;
    logic             grant_i;
    logic             last_beat;

    assign resp      = '{ready: cresp_ready, last: cresp_last, data: cresp_data};
    assign last_beat = resp.ready && resp.last;

    always_comb begin
        starve_hit = ireq_valid && (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);
        grant_d    = dreq_valid && !starve_hit;
        grant_i    = ireq_valid && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            req_q        <= '0;
            starve_cnt   <= '0;
            iresp_data_q <= '0;
            dresp_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        state <= ST_DBUSY;
                        req_q <= '{valid: 1'b1, size: dreq_size, addr: dreq_addr,
                                   strobe: dreq_strobe, data: dreq_data};
                        // Only grants taken while fetch waits count toward starvation.
                        if (!ireq_valid)
                            starve_cnt <= '0;
                        else if (starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (grant_i) begin
                        state      <= ST_IBUSY;
                        req_q      <= '{valid: 1'b1, size: FETCH_SIZE, addr: ireq_addr,
                                        strobe: 8'h00, data: 64'h0};
                        starve_cnt <= '0;
                    end
                end
                ST_IBUSY: begin
                    if (last_beat) begin
                        req_q.valid  <= 1'b0;
                        iresp_data_q <= fetch_word(resp.data, req_q.addr[2]);
                        state        <= ST_IRESP;
                    end
                end
                ST_DBUSY: begin
                    if (last_beat) begin
                        req_q.valid  <= 1'b0;
                        dresp_data_q <= resp.data;
                        state        <= ST_DRESP;
                    end
                end
                ST_IRESP, ST_DRESP: state <= ST_IDLE;
                default:            state <= ST_IDLE;
            endcase
        end
    end

    assign iresp_addr_ok = (state == ST_IRESP);
    assign iresp_data_ok = (state == ST_IRESP);
    assign iresp_data    = iresp_data_q;
    assign dresp_addr_ok = (state == ST_DRESP);
    assign dresp_data_ok = (state == ST_DRESP);
    assign dresp_data    = dresp_data_q;

    assign creq_valid    = req_q.valid;
    assign creq_is_write = |req_q.strobe;
    assign creq_size     = req_q.size;
    assign creq_addr     = req_q.addr;
    assign creq_strobe   = req_q.strobe;
    assign creq_data     = req_q.data;

endmodule
